reg_bank_sequencer: RTL and testbench
=====================================

// Module: reg_bank_sequencer
// PURPOSE
//  Command-side master for the 4x32 register bank: accepts one ALU/move command per handshake,
//  drives the bank read selects, captures both operands, computes the result, writes it back
//  through the bank write port and returns a response. Sits between control logic and the bank.
//  Bank contract: reads are combinational on sr1/sr2; R[dr] <= write_data at posedge clk when write=1.
// PARAMETERS
//  DATA_W   32  register/data width
//  SEL_W    2   register select width (2**SEL_W registers)
// PORTS
//  clk          in   1       clock; all state updates on posedge
//  rst          in   1       synchronous, active-high reset
//  cmd_valid    in   1       command present
//  cmd_ready    out  1       block can accept a command
//  cmd_op       in   3       000 NOP,001 MOVI,010 ADD,011 SUB,100 AND,101 OR,110 XOR,111 READ
//  cmd_dr       in   SEL_W   destination register
//  cmd_sr1      in   SEL_W   source register A
//  cmd_sr2      in   SEL_W   source register B
//  cmd_imm      in   DATA_W  immediate for MOVI
//  sr1          out  SEL_W   bank read select 1
//  sr2          out  SEL_W   bank read select 2
//  dr           out  SEL_W   bank write select
//  write        out  1       bank write enable
//  write_data   out  DATA_W  bank write data
//  read_data_1  in   DATA_W  bank read data for sr1
//  read_data_2  in   DATA_W  bank read data for sr2
//  resp_valid   out  1       response present
//  resp_ready   in   1       consumer accepts response
//  resp_data    out  DATA_W  result (READ/NOP: R[sr1])
//  resp_carry   out  1       ADD carry-out / SUB borrow; 0 for other ops
//  resp_zero    out  1       resp_data == 0
//  busy         out  1       state != IDLE
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state IDLE; sr1/sr2/dr/write_data/resp_* = 0; write=0, resp_valid=0.
//    cmd_ready = (state==IDLE) && !rst. Reset mid-command aborts it; no response is produced.
//  - write = (state==WRITE) && !rst (combinational): rst asserted during WRITE suppresses the bank write.
//  - FSM: IDLE -> READ on cmd_valid&&cmd_ready; command fields latched at that edge.
//    READ: sr1/sr2 driven from latched selects; read_data_1/2 registered into opA/opB at end of cycle.
//    EXEC: result/carry/zero computed from opA/opB, registered.
//    EXEC -> WRITE for MOVI/ADD/SUB/AND/OR/XOR; EXEC -> RESP for NOP/READ (no bank write).
//    WRITE: one cycle, write=1, dr=latched dr, write_data=result. WRITE -> RESP.
//    RESP: resp_valid=1, resp_* stable until resp_valid&&resp_ready; then -> IDLE.
//  - Latency: accept edge to resp_valid high = 4 cycles (write ops), 3 cycles (NOP/READ).
//  - One command in flight; next command accepted no earlier than the cycle after the response
//    handshake, so its operand reads observe the previous write.
//  - Arithmetic: DATA_W-bit modulo wrap. ADD carry = bit DATA_W of opA+opB. SUB = opA-opB,
//    carry = (opA < opB) unsigned. MOVI result = cmd_imm; selects irrelevant.
//  - sr1==sr2==dr permitted: operands read before write, e.g. ADD R1,R1,R1 doubles R1.
//  - cmd_* ignored outside IDLE; cmd_valid may drop without effect while cmd_ready=0.
//  - sr1/sr2/dr hold last driven values outside READ/WRITE.
// TESTING
//  - Reset: rst 2 cycles -> write=0, resp_valid=0, busy=0, cmd_ready=1 first cycle after release.
//  - MOVI R2,0xDEADBEEF then READ R2 -> write pulse 1 cycle dr=2; READ resp_data=0xDEADBEEF, zero=0.
//  - R0=0xFFFFFFFF,R1=1; ADD R3,R0,R1 -> R3=0, resp_carry=1, resp_zero=1; latency 4 cycles.
//  - R0=5,R1=7; SUB R0,R0,R1 -> R0=0xFFFFFFFE, carry=1; then XOR R0,R0,R0 -> R0=0, zero=1.
//  - Backpressure: resp_ready low 5 cycles -> resp_* stable, cmd_ready=0 throughout, no extra write.
//  - rst asserted in WRITE of ADD R1 -> write=0 that cycle, R1 unchanged, no resp_valid.

Source files
------------

// File: rtl/reg_bank_sequencer.sv
// Command-side master for a 4x32 register bank. Each command runs through the
// sequence IDLE -> READ -> EXEC -> [WRITE] -> RESP, with one command in flight.
module reg_bank_sequencer #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [SEL_W-1:0]  cmd_dr,
    input  logic [SEL_W-1:0]  cmd_sr1,
    input  logic [SEL_W-1:0]  cmd_sr2,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [SEL_W-1:0]  sr1,
    output logic [SEL_W-1:0]  sr2,
    output logic [SEL_W-1:0]  dr,
    output logic              write,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data_1,
    input  logic [DATA_W-1:0] read_data_2,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_carry,
    output logic              resp_zero,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WRITE,
        S_RESP
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_MOVI = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_XOR  = 3'b110,
        OP_READ = 3'b111
    } op_t;

    state_t state, next_state;

    op_t               op_q;
    logic [SEL_W-1:0]  dr_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] op_a, op_b;

    logic              accept;
    logic              op_writes;
    logic [DATA_W:0]   add_sum;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              alu_zero;

    assign accept     = cmd_valid && cmd_ready;
    assign cmd_ready  = (state == S_IDLE) && !rst;
    // Gated with rst so a reset landing in WRITE never commits to the bank.
    assign write      = (state == S_WRITE) && !rst;
    assign resp_valid = (state == S_RESP);
    assign busy       = (state != S_IDLE);
    assign op_writes  = (op_q != OP_NOP) && (op_q != OP_READ);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; combinational blocks use blocking (=).
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of an always_comb gets a default first, so no path
    // through the case leaves a variable unassigned and infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (accept) next_state = S_READ;
            S_READ:  next_state = S_EXEC;
            S_EXEC:  next_state = op_writes ? S_WRITE : S_RESP;
            S_WRITE: next_state = S_RESP;
            S_RESP:  if (resp_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    assign add_sum = {1'b0, op_a} + {1'b0, op_b};

    always_comb begin
        alu_result = '0;
        alu_carry  = 1'b0;
        case (op_q)
            OP_MOVI: alu_result = imm_q;
            OP_ADD: begin
                alu_result = add_sum[DATA_W-1:0];
                alu_carry  = add_sum[DATA_W];
            end
            OP_SUB: begin
                alu_result = op_a - op_b;
                alu_carry  = (op_a < op_b);
            end
            OP_AND:  alu_result = op_a & op_b;
            OP_OR:   alu_result = op_a | op_b;
            OP_XOR:  alu_result = op_a ^ op_b;
            default: alu_result = op_a;   // NOP and READ return R[sr1]
        endcase
    end

    assign alu_zero = (alu_result == '0);

    // NOTE: command and operand holding registers are deliberately not reset;
    // they are always loaded before being consumed, so a reset adds only cost.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q  <= op_t'(cmd_op);
            dr_q  <= cmd_dr;
            imm_q <= cmd_imm;
        end
        if (state == S_READ) begin
            op_a <= read_data_1;
            op_b <= read_data_2;
        end
    end

    // Visible outputs reset to zero and otherwise hold until next driven.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr1        <= '0;
            sr2        <= '0;
            dr         <= '0;
            write_data <= '0;
            resp_data  <= '0;
            resp_carry <= 1'b0;
            resp_zero  <= 1'b0;
        end else begin
            if (accept) begin
                sr1 <= cmd_sr1;
                sr2 <= cmd_sr2;
            end
            if (state == S_EXEC) begin
                resp_data  <= alu_result;
                resp_carry <= alu_carry;
                resp_zero  <= alu_zero;
                if (op_writes) begin
                    dr         <= dr_q;
                    write_data <= alu_result;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_bank_sequencer.sv
// Directed bench for reg_bank_sequencer: a behavioural register bank, a response
// scoreboard fed by the stimulus tasks and drained by an independent monitor.
module tb_reg_bank_sequencer;

    localparam int DATA_W = 32;
    localparam int SEL_W  = 2;

    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] MOVI = 3'b001;
    localparam logic [2:0] ADD  = 3'b010;
    localparam logic [2:0] SUB  = 3'b011;
    localparam logic [2:0] AND_ = 3'b100;
    localparam logic [2:0] OR_  = 3'b101;
    localparam logic [2:0] XOR_ = 3'b110;
    localparam logic [2:0] READ = 3'b111;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [SEL_W-1:0]  cmd_dr, cmd_sr1, cmd_sr2;
    logic [DATA_W-1:0] cmd_imm;
    logic [SEL_W-1:0]  sr1, sr2, dr;
    logic              write;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data_1, read_data_2;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              resp_carry;
    logic              resp_zero;
    logic              busy;

    reg_bank_sequencer #(.DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dr(cmd_dr), .cmd_sr1(cmd_sr1), .cmd_sr2(cmd_sr2), .cmd_imm(cmd_imm),
        .sr1(sr1), .sr2(sr2), .dr(dr), .write(write), .write_data(write_data),
        .read_data_1(read_data_1), .read_data_2(read_data_2),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_carry(resp_carry), .resp_zero(resp_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural bank: combinational reads, write on posedge.
    logic [DATA_W-1:0] bank [4];
    initial for (int i = 0; i < 4; i++) bank[i] = '0;
    always @(posedge clk) if (write) bank[dr] <= write_data;
    assign read_data_1 = bank[sr1];
    assign read_data_2 = bank[sr2];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              carry;
        logic              zero;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Monitor: compares every accepted response against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", resp_valid, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_data",  resp_data,  mon_e.data);
                check("resp_carry", resp_carry, mon_e.carry);
                check("resp_zero",  resp_zero,  mon_e.zero);
            end
        end
    end

    // Write-pulse tracking.
    int                wr_count = 0;
    logic [SEL_W-1:0]  last_dr;
    logic [DATA_W-1:0] last_wd;
    always @(negedge clk) begin
        if (write) begin
            wr_count <= wr_count + 1;
            last_dr  <= dr;
            last_wd  <= write_data;
        end
    end

    task automatic send_cmd(input logic [2:0] op, input logic [1:0] d, input logic [1:0] s1,
                            input logic [1:0] s2, input logic [31:0] imm);
        bit ok = 1'b0;
        cmd_op = op; cmd_dr = d; cmd_sr1 = s1; cmd_sr2 = s2; cmd_imm = imm;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check("cmd_ready_timeout", cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Issue one command, check latency, write pulse and optional backpressure hold.
    task automatic issue(input string name, input logic [2:0] op, input logic [1:0] d,
                         input logic [1:0] s1, input logic [1:0] s2, input logic [31:0] imm,
                         input logic [31:0] e_data, input logic e_carry, input logic e_zero,
                         input int hold);
        int   wc0;
        int   lat = 0;
        bit   seen = 1'b0;
        bit   is_wr;
        logic [DATA_W-1:0] cap_d;
        logic cap_c, cap_z;
        is_wr = (op != NOP) && (op != READ);
        exp_q.push_back('{data: e_data, carry: e_carry, zero: e_zero});
        wc0 = wr_count;
        if (hold > 0) resp_ready = 1'b0;
        send_cmd(op, d, s1, s2, imm);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (resp_valid) begin seen = 1'b1; break; end
        end
        if (!seen) check({name, "_resp_timeout"}, resp_valid, 1'b1);
        check({name, "_latency"}, lat, is_wr ? 4 : 3);
        if (hold > 0) begin
            cap_d = resp_data; cap_c = resp_carry; cap_z = resp_zero;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check({name, "_bp_valid"}, resp_valid, 1'b1);
                check({name, "_bp_data"},  {resp_data, resp_carry, resp_zero}, {cap_d, cap_c, cap_z});
                check({name, "_bp_ready"}, cmd_ready, 1'b0);
                check({name, "_bp_write"}, write, 1'b0);
            end
            @(posedge clk); #1;
            resp_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        check({name, "_writes"}, wr_count - wc0, is_wr ? 1 : 0);
        if (is_wr) begin
            check({name, "_wr_dr"},   last_dr, d);
            check({name, "_wr_data"}, last_wd, e_data);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc0;
        rst = 1'b1; cmd_valid = 1'b0; resp_ready = 1'b1;
        cmd_op = NOP; cmd_dr = '0; cmd_sr1 = '0; cmd_sr2 = '0; cmd_imm = '0;

        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_write", write, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_write", write, 1'b0);
        check("post_rst_resp_valid", resp_valid, 1'b0);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_cmd_ready", cmd_ready, 1'b1);
        check("post_rst_outputs", {sr1, sr2, dr, write_data, resp_data, resp_carry, resp_zero}, '0);
        @(posedge clk); #1;

        issue("movi_r2",  MOVI, 2'd2, 2'd0, 2'd0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 0);
        issue("read_r2",  READ, 2'd0, 2'd2, 2'd0, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 0);

        issue("movi_r0",  MOVI, 2'd0, 2'd0, 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 0);
        issue("movi_r1",  MOVI, 2'd1, 2'd0, 2'd0, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 0);
        issue("add_wrap", ADD,  2'd3, 2'd0, 2'd1, 32'h0,        32'h00000000, 1'b1, 1'b1, 0);
        issue("read_r3",  READ, 2'd0, 2'd3, 2'd0, 32'h0,        32'h00000000, 1'b0, 1'b1, 0);

        issue("movi_r0_5", MOVI, 2'd0, 2'd0, 2'd0, 32'd5, 32'd5, 1'b0, 1'b0, 0);
        issue("movi_r1_7", MOVI, 2'd1, 2'd0, 2'd0, 32'd7, 32'd7, 1'b0, 1'b0, 0);
        issue("sub_borrow", SUB, 2'd0, 2'd0, 2'd1, 32'h0, 32'hFFFFFFFE, 1'b1, 1'b0, 0);
        issue("xor_self",  XOR_, 2'd0, 2'd0, 2'd0, 32'h0, 32'h00000000, 1'b0, 1'b1, 0);
        issue("read_r0",   READ, 2'd0, 2'd0, 2'd0, 32'h0, 32'h00000000, 1'b0, 1'b1, 0);

        issue("movi_r2_f0", MOVI, 2'd2, 2'd0, 2'd0, 32'hF0F0F0F0, 32'hF0F0F0F0, 1'b0, 1'b0, 0);
        issue("or_r3",      OR_,  2'd3, 2'd2, 2'd1, 32'h0, 32'hF0F0F0F7, 1'b0, 1'b0, 0);
        issue("and_r3",     AND_, 2'd3, 2'd2, 2'd3, 32'h0, 32'hF0F0F0F0, 1'b0, 1'b0, 0);
        issue("add_double", ADD,  2'd1, 2'd1, 2'd1, 32'h0, 32'h0000000E, 1'b0, 1'b0, 0);
        issue("nop_r3",     NOP,  2'd0, 2'd3, 2'd0, 32'h0, 32'hF0F0F0F0, 1'b0, 1'b0, 0);
        issue("sub_equal",  SUB,  2'd2, 2'd1, 2'd1, 32'h0, 32'h00000000, 1'b0, 1'b1, 0);
        issue("movi_zero",  MOVI, 2'd2, 2'd3, 2'd3, 32'h0, 32'h00000000, 1'b0, 1'b1, 0);

        issue("add_backpressure", ADD, 2'd1, 2'd1, 2'd1, 32'h0, 32'h0000001C, 1'b0, 1'b0, 5);

        // Reset lands in the WRITE cycle of ADD R1,R1,R1: no write, no response.
        wc0 = wr_count;
        send_cmd(ADD, 2'd1, 2'd1, 2'd1, 32'h0);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy_in_write", busy, 1'b1);
        check("abort_write_suppressed", write, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_resp", resp_valid, 1'b0);
        end
        check("abort_idle", busy, 1'b0);
        check("abort_no_write", wr_count - wc0, 0);
        @(posedge clk); #1;
        issue("read_r1_after_abort", READ, 2'd0, 2'd1, 2'd0, 32'h0, 32'h0000001C, 1'b0, 1'b0, 0);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
